dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data memory between the pipeline's Memory-stage load/store port and a word-wide debug/loader port. It turns byte and halfword stores into a two-cycle read-modify-write (RMW) on the word-wide memory. It raises a stall request into the hazard unit while the CPU access cannot complete in the current cycle. A saturating starvation counter guarantees the debug port forward progress under continuous CPU traffic.

## Interface
Parameters:
- AW, 32, address width
- STARVE_MAX, 4, consecutive denied debug cycles before debug preempts the CPU (1..15)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  Memory-stage access valid (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- cpu_addr  in  AW  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  raw aligned word; the datapath extracts and extends it
- cpu_stall  out  1  to hazard unit; freezes the pipeline this cycle
- dbg_req  in  1  debug request; held high until dbg_ack
- dbg_we  in  1  debug store (word only)
- dbg_addr  in  AW  debug byte address; bits [1:0] ignored
- dbg_wdata  in  32  debug store data
- dbg_rdata  out  32  registered read data, valid with dbg_ack
- dbg_ack  out  1  one-cycle completion pulse
- mem_we  out  1  memory write enable (memory writes on rising clk)
- mem_addr  out  AW  word-aligned address: {addr[AW-1:2], 2'b00}
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data

## Operation
- States: IDLE, RMW_WR, DBG_ACK.
- IDLE, debug grant:
  - Condition: dbg_req && (!cpu_req || starve==STARVE_MAX).
  - Drive the memory from the debug port and capture mem_rdata into dbg_rdata.
  - cpu_stall = cpu_req; starve clears; next state DBG_ACK.
- IDLE, CPU access, else if cpu_req:
  - Load or word store: pass-through with mem_we = cpu_we and mem_wdata = cpu_wdata. cpu_stall = 0; stay in IDLE.
  - Sub-word store: mem_we = 0 (read phase). Register the merged word, register the word address, set cpu_stall = 1, next state RMW_WR.
- Merge rules:
  - Byte lane = addr[1:0]; only that byte is replaced by wdata[7:0].
  - Half lane = addr[1]; addr[0] is ignored. That halfword is replaced by wdata[15:0].
- RMW_WR:
  - mem_we = 1 with the registered word and address; cpu_stall = 0, so the store retires.
  - Debug cannot be granted here; next state IDLE.
- DBG_ACK:
  - dbg_ack = 1. The CPU is served exactly as in IDLE, including starting an RMW, which moves to RMW_WR.
  - Debug is never granted; otherwise next state IDLE.
- Starvation counter: 4-bit, saturating at STARVE_MAX.
  - Increments on every cycle with dbg_req high and no debug grant, in any state.
  - Clears on a debug grant.
- cpu_rdata = mem_rdata in every cycle. It is meaningful only when cpu_stall = 0.

## Timing
- Reset values: state IDLE, starve 0, dbg_ack 0, dbg_rdata 0, cpu_stall 0, mem_we 0. Reset asserted during RMW_WR aborts the write; no partial write is issued.
- Latencies:
  - Load / word store: 0 extra cycles.
  - Sub-word store: 1 stall cycle, with the write on the second edge.
  - Debug access: the access takes effect at the grant-cycle edge; dbg_ack follows in the next cycle.
- Worst-case debug wait under continuous CPU traffic: STARVE_MAX denied cycles plus one RMW completion cycle.
- Simultaneous events:
  - CPU and debug in IDLE with starve < STARVE_MAX: CPU wins.
  - Debug preempting a sub-word store: the RMW starts after DBG_ACK. Its read happens after the debug write, so the merge sees fresh data.
- If dbg_req drops before grant, no ack is issued and starve clears to 0 on the next edge.

## Structure
- Shared package: the cpu_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
- One sub-module: store_merge. It is combinational and computes the merged word from the old word, wdata, size and addr[1:0].
- Everything else stays flat in dmem_arbiter.

## Test plan
- Word 96 = 0xAA0BC0DD; CPU sb 0x33 @96 -> one cycle of cpu_stall, then memory 0xAA0BC033; the other bytes are unchanged.
- Word 96 = 0xAA0BC0DD; CPU sh 0x1234 @98 -> memory 0x1234C0DD; sh @97 is treated as the lane-0 half -> 0xAA0B1234.
- Debug write 0x0000001E @40 with cpu_req low -> mem_we in the grant cycle, dbg_ack exactly one cycle later; a debug read @40 then returns 30 on dbg_rdata.
- cpu_req held high with back-to-back loads, dbg_req high -> STARVE_MAX (4) denied cycles, then one grant with cpu_stall = 1, then starve = 0.
- Sub-word store and dbg_req arrive together in IDLE with starve = STARVE_MAX -> debug first, then the RMW read sees the debug-written word.
- Reset asserted in RMW_WR -> no memory write, all outputs reset; the first post-reset word store passes with zero stall.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes and FSM states.
package dmem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RMW_WR  = 2'b01,
        ST_DBG_ACK = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_arbiter_store_merge.sv
// Combinational byte/halfword lane merge used by the read-modify-write store path.
module store_merge
    import dmem_arbiter_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            // addr[0] is ignored for halfwords: lane is chosen by addr[1] alone
            SZ_HALF: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU Memory stage and a debug port,
// with sub-word stores done as read-modify-write and a starvation counter for debug.
//   state      | meaning
//   ST_IDLE    | CPU pass-through; debug granted if CPU idle or debug starved
//   ST_RMW_WR  | write phase of a sub-word store; debug blocked
//   ST_DBG_ACK | dbg_ack pulse; CPU served as in IDLE, no debug grant
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_size,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [31:0]   merged_q, merged_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          dbg_ack_q;
    logic [31:0]   dbg_rdata_q;

    logic          dbg_grant;
    logic          cpu_subword;
    logic          mem_we_raw;
    logic          cpu_stall_raw;
    logic [31:0]   merged_word;
    logic          unused_dbg_lo;

    assign unused_dbg_lo = ^dbg_addr[1:0];

    assign cpu_subword = cpu_we && (cpu_size == SZ_BYTE || cpu_size == SZ_HALF);
    assign dbg_grant   = (state_q == ST_IDLE) && dbg_req &&
                         (!cpu_req || starve_q == STARVE_LIM);

    store_merge u_store_merge (
        .old_word_i (mem_rdata),
        .wdata_i    (cpu_wdata),
        .size_i     (cpu_size),
        .addr_lo_i  (cpu_addr[1:0]),
        .merged_o   (merged_word)
    );

    always_comb begin
        state_d       = ST_IDLE;
        merged_d      = merged_q;
        waddr_d       = waddr_q;
        mem_we_raw    = 1'b0;
        mem_addr      = {cpu_addr[AW-1:2], 2'b00};
        mem_wdata     = cpu_wdata;
        cpu_stall_raw = 1'b0;

        if (state_q == ST_RMW_WR) begin
            mem_we_raw = 1'b1;
            mem_addr   = waddr_q;
            mem_wdata  = merged_q;
        end else if (dbg_grant) begin
            mem_we_raw    = dbg_we;
            mem_addr      = {dbg_addr[AW-1:2], 2'b00};
            mem_wdata     = dbg_wdata;
            cpu_stall_raw = cpu_req;
            state_d       = ST_DBG_ACK;
        end else if (cpu_req) begin
            if (cpu_subword) begin
                merged_d      = merged_word;
                waddr_d       = {cpu_addr[AW-1:2], 2'b00};
                cpu_stall_raw = 1'b1;
                state_d       = ST_RMW_WR;
            end else begin
                mem_we_raw = cpu_we;
            end
        end

        if (dbg_grant)
            starve_d = 4'd0;
        else if (dbg_req)
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        else
            starve_d = 4'd0;
    end

    // Reset gates the strobes so no write or stall escapes while reset is held.
    assign mem_we    = mem_we_raw && !reset;
    assign cpu_stall = cpu_stall_raw && !reset;
    assign cpu_rdata = mem_rdata;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= 4'd0;
            merged_q    <= 32'd0;
            waddr_q     <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            merged_q  <= merged_d;
            waddr_q   <= waddr_d;
            dbg_ack_q <= dbg_grant;
            if (dbg_grant)
                dbg_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    dmem_arbiter #(.AW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_set(input logic req, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_size = sz; cpu_addr = addr; cpu_wdata = wd;
        #1;
    endtask

    task automatic word_store(input logic [31:0] addr, input logic [31:0] wd);
        cpu_set(1'b1, 1'b1, 2'b10, addr, wd);
        tick();
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cpu_set(1'b1, 1'b0, 2'b10, addr, 32'd0);
        check(tag, cpu_rdata, exp);
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
    endtask

    // Sub-word store: one stall cycle, write in the following cycle.
    task automatic subword_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] exp_word);
        cpu_set(1'b1, 1'b1, sz, addr, wd);
        check({tag, " stall"}, {31'd0, cpu_stall}, 32'd1);
        check({tag, " rd_we"}, {31'd0, mem_we}, 32'd0);
        tick();
        check({tag, " wr_we"}, {31'd0, mem_we}, 32'd1);
        check({tag, " wr_stall"}, {31'd0, cpu_stall}, 32'd0);
        check({tag, " wdata"}, mem_wdata, exp_word);
        check({tag, " waddr"}, mem_addr, {addr[31:2], 2'b00});
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        tick();
        load_check({tag, " mem"}, addr, exp_word);
    endtask

    int cnt;

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        tick(); tick();
        check("rst dbg_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst dbg_rdata", dbg_rdata, 32'd0);
        check("rst cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        tick();

        // Byte and halfword RMW on word 96
        word_store(32'd96, 32'hAA0BC0DD);
        subword_store("sb96", 2'b00, 32'd96, 32'h00000033, 32'hAA0BC033);
        word_store(32'd96, 32'hAA0BC0DD);
        subword_store("sh98", 2'b01, 32'd98, 32'h00001234, 32'h1234C0DD);
        word_store(32'd96, 32'hAA0BC0DD);
        subword_store("sh97", 2'b01, 32'd97, 32'h00001234, 32'hAA0B1234);
        word_store(32'd96, 32'hAA0BC0DD);
        subword_store("sb99", 2'b00, 32'd99, 32'hFFFFFF77, 32'h770BC0DD);

        // Word store with size 11: zero-stall pass-through
        cpu_set(1'b1, 1'b1, 2'b11, 32'd100, 32'hDEADBEEF);
        check("sw stall", {31'd0, cpu_stall}, 32'd0);
        check("sw we", {31'd0, mem_we}, 32'd1);
        tick();
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        load_check("sw mem", 32'd100, 32'hDEADBEEF);

        // Debug write then read at 40, CPU idle
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'd42; dbg_wdata = 32'h0000001E;
        #1;
        check("dbgw we", {31'd0, mem_we}, 32'd1);
        check("dbgw addr", mem_addr, 32'd40);
        check("dbgw data", mem_wdata, 32'h0000001E);
        check("dbgw ack0", {31'd0, dbg_ack}, 32'd0);
        tick();
        check("dbgw ack1", {31'd0, dbg_ack}, 32'd1);
        dbg_req = 0; dbg_we = 0;
        tick();
        check("dbgw ack2", {31'd0, dbg_ack}, 32'd0);
        dbg_req = 1; dbg_addr = 32'd43;
        tick();
        check("dbgr ack", {31'd0, dbg_ack}, 32'd1);
        check("dbgr data", dbg_rdata, 32'd30);
        dbg_req = 0;
        tick();

        // Starvation under back-to-back loads
        for (int r = 0; r < 2; r++) begin
            cpu_set(1'b1, 1'b0, 2'b10, 32'd96, 32'd0);
            dbg_req = 1; dbg_we = 0; dbg_addr = 32'd40;
            #1;
            cnt = 0;
            while (!cpu_stall && cnt < 20) begin
                check("starve ack_low", {31'd0, dbg_ack}, 32'd0);
                tick();
                cnt++;
            end
            check("starve denials", cnt, 32'd4);
            check("starve grant_addr", mem_addr, 32'd40);
            tick();
            check("starve ack", {31'd0, dbg_ack}, 32'd1);
            check("starve rdata", dbg_rdata, 32'd30);
            check("starve cpu_free", {31'd0, cpu_stall}, 32'd0);
            dbg_req = 0;
            tick();
        end
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        tick();

        // Debug preempts a byte store; RMW reads the debug-written word
        word_store(32'd96, 32'hAA0BC0DD);
        cpu_set(1'b1, 1'b0, 2'b10, 32'd100, 32'd0);
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'd96; dbg_wdata = 32'h11223344;
        for (int i = 0; i < 4; i++) tick();
        cpu_set(1'b1, 1'b1, 2'b00, 32'd97, 32'h00000055);
        check("pre grant_we", {31'd0, mem_we}, 32'd1);
        check("pre grant_data", mem_wdata, 32'h11223344);
        check("pre grant_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        check("pre ack", {31'd0, dbg_ack}, 32'd1);
        check("pre rd_stall", {31'd0, cpu_stall}, 32'd1);
        check("pre rd_we", {31'd0, mem_we}, 32'd0);
        dbg_req = 0; dbg_we = 0;
        tick();
        check("pre wr_we", {31'd0, mem_we}, 32'd1);
        check("pre wr_data", mem_wdata, 32'h11225544);
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        tick();
        load_check("pre mem", 32'd96, 32'h11225544);

        // Reset during RMW_WR aborts the write
        cpu_set(1'b1, 1'b1, 2'b00, 32'd96, 32'h00000099);
        tick();
        check("rrmw in_wr", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rrmw we", {31'd0, mem_we}, 32'd0);
        check("rrmw stall", {31'd0, cpu_stall}, 32'd0);
        check("rrmw ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        load_check("rrmw mem", 32'd96, 32'h11225544);
        cpu_set(1'b1, 1'b1, 2'b10, 32'd96, 32'hCAFEF00D);
        check("post sw stall", {31'd0, cpu_stall}, 32'd0);
        check("post sw we", {31'd0, mem_we}, 32'd1);
        tick();
        cpu_set(1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        load_check("post sw mem", 32'd96, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
